// File: rtl/arbitro_mux2.sv
// Round-robin owner arbiter and registered select/data stage for a shared 2:1 datapath mux.
// Optional build macro ARBITRO_PRIORIDADE_FIXA_EN: requester 0 wins ties and is never preempted.
module arbitro_mux2 #(
   parameter int LARGURA    = 4,
   parameter int MAX_RAJADA = 4
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Requisicao0,
   input  logic               Requisicao1,
   input  logic [LARGURA-1:0] Entrada0,
   input  logic [LARGURA-1:0] Entrada1,
   output logic               Concessao0,
   output logic               Concessao1,
   output logic               Controle,
   output logic [LARGURA-1:0] Resultado,
   output logic               Valido
);

   localparam int CW = (MAX_RAJADA > 1) ? $clog2(MAX_RAJADA) : 1;
   localparam logic [CW-1:0] LIMITE = CW'(MAX_RAJADA - 1);

`ifdef ARBITRO_PRIORIDADE_FIXA_EN
   localparam logic LIMITE0_EN = 1'b0;
`else
   localparam logic LIMITE0_EN = 1'b1;
`endif

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      DONO0  = 2'd1,
      DONO1  = 2'd2
   } estado_t;

   estado_t            estado_q, estado_d;
   logic [CW-1:0]      contador_q, contador_d;
   logic               ultimo_q, ultimo_d;
   logic [LARGURA-1:0] resultado_q, resultado_d;
   logic               valido_q, valido_d;
   logic               conc0_q, conc1_q, controle_q;

   // Next-state, burst accounting and beat capture
   always_comb begin
      estado_d    = estado_q;
      contador_d  = contador_q;
      ultimo_d    = ultimo_q;
      resultado_d = resultado_q;
      valido_d    = 1'b0;
      case (estado_q)
         OCIOSO: begin
            contador_d = {CW{1'b0}};
            if (Requisicao0 && Requisicao1) begin
`ifdef ARBITRO_PRIORIDADE_FIXA_EN
               estado_d = DONO0;
`else
               estado_d = ultimo_q ? DONO0 : DONO1;
`endif
            end else if (Requisicao0) begin
               estado_d = DONO0;
            end else if (Requisicao1) begin
               estado_d = DONO1;
            end else begin
               estado_d = OCIOSO;
            end
         end
         DONO0: begin
            if (Requisicao0) begin
               resultado_d = Entrada0;
               valido_d    = 1'b1;
               if (contador_q == LIMITE) begin
                  contador_d = {CW{1'b0}};
                  if (Requisicao1 && LIMITE0_EN) begin
                     estado_d = DONO1;
                     ultimo_d = 1'b0;
                  end else begin
                     estado_d = DONO0;
                  end
               end else begin
                  contador_d = contador_q + {{(CW-1){1'b0}}, 1'b1};
               end
            end else begin
               // Release: no beat, hand over or go idle
               contador_d = {CW{1'b0}};
               ultimo_d   = 1'b0;
               estado_d   = Requisicao1 ? DONO1 : OCIOSO;
            end
         end
         DONO1: begin
            if (Requisicao1) begin
               resultado_d = Entrada1;
               valido_d    = 1'b1;
               if (contador_q == LIMITE) begin
                  contador_d = {CW{1'b0}};
                  if (Requisicao0) begin
                     estado_d = DONO0;
                     ultimo_d = 1'b1;
                  end else begin
                     estado_d = DONO1;
                  end
               end else begin
                  contador_d = contador_q + {{(CW-1){1'b0}}, 1'b1};
               end
            end else begin
               contador_d = {CW{1'b0}};
               ultimo_d   = 1'b1;
               estado_d   = Requisicao0 ? DONO0 : OCIOSO;
            end
         end
         default: begin
            estado_d   = OCIOSO;
            contador_d = {CW{1'b0}};
            ultimo_d   = 1'b1;
         end
      endcase
   end

   // State and registered outputs; grants decode the next state so they track ownership exactly
   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado_q    <= OCIOSO;
         contador_q  <= {CW{1'b0}};
         ultimo_q    <= 1'b1;
         resultado_q <= {LARGURA{1'b0}};
         valido_q    <= 1'b0;
         conc0_q     <= 1'b0;
         conc1_q     <= 1'b0;
         controle_q  <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         contador_q  <= contador_d;
         ultimo_q    <= ultimo_d;
         resultado_q <= resultado_d;
         valido_q    <= valido_d;
         conc0_q     <= (estado_d == DONO0);
         conc1_q     <= (estado_d == DONO1);
         controle_q  <= (estado_d == DONO1);
      end
   end

   assign Concessao0 = conc0_q;
   assign Concessao1 = conc1_q;
   assign Controle   = controle_q;
   assign Resultado  = resultado_q;
   assign Valido     = valido_q;

endmodule

// File: tb/tb_arbitro_mux2.sv
// Directed scoreboard bench for arbitro_mux2 (default round-robin build, LARGURA=4, MAX_RAJADA=4).
module tb_arbitro_mux2;

   logic       Clock = 1'b0;
   logic       Reset, Requisicao0, Requisicao1;
   logic [3:0] Entrada0, Entrada1;
   logic       Concessao0, Concessao1, Controle, Valido;
   logic [3:0] Resultado;

   typedef struct {
      logic       g0;
      logic       g1;
      logic       ctl;
      logic       v;
      logic [3:0] res;
      int         id;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   n_cyc = 0;
   logic stim_done = 1'b0;

   arbitro_mux2 #(.LARGURA(4), .MAX_RAJADA(4)) dut (
      .Clock(Clock), .Reset(Reset),
      .Requisicao0(Requisicao0), .Requisicao1(Requisicao1),
      .Entrada0(Entrada0), .Entrada1(Entrada1),
      .Concessao0(Concessao0), .Concessao1(Concessao1),
      .Controle(Controle), .Resultado(Resultado), .Valido(Valido)
   );

   always #5 Clock = ~Clock;

   // Drive one cycle of inputs and queue the outputs expected after the coming edge
   task automatic cyc(input logic rst, input logic r0, input logic r1,
                      input logic [3:0] e0, input logic [3:0] e1,
                      input logic g0, input logic g1, input logic ctl,
                      input logic v, input logic [3:0] res);
      exp_t e;
      @(negedge Clock);
      Reset = rst; Requisicao0 = r0; Requisicao1 = r1;
      Entrada0 = e0; Entrada1 = e1;
      n_cyc++;
      e.g0 = g0; e.g1 = g1; e.ctl = ctl; e.v = v; e.res = res; e.id = n_cyc;
      q.push_back(e);
   endtask

   // Monitor: after every edge pop the expectation and compare all outputs
   initial begin
      exp_t e;
      forever begin
         @(posedge Clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (Concessao0 !== e.g0 || Concessao1 !== e.g1 || Controle !== e.ctl ||
                Valido !== e.v || Resultado !== e.res) begin
               miscompares++;
               $display("FAIL cycle%0d: got g0=%b g1=%b ctl=%b v=%b res=%h, want g0=%b g1=%b ctl=%b v=%b res=%h",
                        e.id, Concessao0, Concessao1, Controle, Valido, Resultado,
                        e.g0, e.g1, e.ctl, e.v, e.res);
            end
         end
      end
   end

   initial begin
      Reset = 1'b1; Requisicao0 = 1'b0; Requisicao1 = 1'b0;
      Entrada0 = 4'h0; Entrada1 = 4'h0;

      // Reset then idle
      cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

      // Single requester 0: one arbitration cycle then three beats
      cyc(1'b0, 1'b1, 1'b0, 4'h7, 4'h0,  1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7);
      cyc(1'b0, 1'b0, 1'b0, 4'h7, 4'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'h7);
      cyc(1'b0, 1'b0, 1'b0, 4'h7, 4'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'h7);

      // Simultaneous requests from reset: 4 beats each, no bubble on switch
      cyc(1'b1, 1'b1, 1'b1, 4'h7, 4'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h0,  1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7);
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h0,  1'b0, 1'b1, 1'b1, 1'b1, 4'h7);
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'h7);

      // Early release after 2 beats of owner 0: one Valido=0 cycle, then owner 1
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h5,  1'b1, 1'b0, 1'b0, 1'b1, 4'h7);
      cyc(1'b0, 1'b0, 1'b1, 4'h7, 4'h5,  1'b0, 1'b1, 1'b1, 1'b0, 4'h7);
      cyc(1'b0, 1'b0, 1'b1, 4'h7, 4'h5,  1'b0, 1'b1, 1'b1, 1'b1, 4'h5);
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h5,  1'b0, 1'b1, 1'b1, 1'b1, 4'h5);

      // Reset on the third beat of owner 1, then the tie goes to requester 0
      cyc(1'b1, 1'b1, 1'b1, 4'h7, 4'h5,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h5,  1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h5,  1'b1, 1'b0, 1'b0, 1'b1, 4'h7);
      cyc(1'b0, 1'b0, 1'b0, 4'h7, 4'h5,  1'b0, 1'b0, 1'b0, 1'b0, 4'h7);
      cyc(1'b0, 1'b0, 1'b0, 4'h7, 4'h5,  1'b0, 1'b0, 1'b0, 1'b0, 4'h7);

      // Tie after requester 0 was last owner goes to requester 1
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h5,  1'b0, 1'b1, 1'b1, 1'b0, 4'h7);
      cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h5,  1'b0, 1'b1, 1'b1, 1'b1, 4'h5);
      cyc(1'b0, 1'b0, 1'b0, 4'h7, 4'h5,  1'b0, 1'b0, 1'b0, 1'b0, 4'h5);

      // Lone requester 1 beyond the burst limit keeps ownership (counter wraps)
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'h1,  1'b0, 1'b1, 1'b1, 1'b0, 4'h5);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'h1,  1'b0, 1'b1, 1'b1, 1'b1, 4'h1);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'h2,  1'b0, 1'b1, 1'b1, 1'b1, 4'h2);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'h3,  1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'h4,  1'b0, 1'b1, 1'b1, 1'b1, 4'h4);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'h6,  1'b0, 1'b1, 1'b1, 1'b1, 4'h6);
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h9,  1'b0, 1'b0, 1'b0, 1'b0, 4'h6);

      stim_done = 1'b1;
   end

   // Bounded end of test: drain the scoreboard, then summarise
   initial begin
      int budget;
      budget = 0;
      while (!stim_done && budget < 2000) begin
         @(posedge Clock);
         budget++;
      end
      repeat (3) @(posedge Clock);
      #2;
      if (!stim_done || q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: done=%b pending=%0d, want done=1 pending=0", stim_done, q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/arbitro_mux2.md
Name: arbitro_mux2

Overview:
- Round-robin arbiter and sequencer for the shared 2:1 datapath multiplexer (MUX2_3 class, 4-bit default).
- Two requesters each present a data word. The block decides who owns the mux, drives its select line (Controle), and registers the selected word with a valid flag.
- Bounded bursts stop one requester from starving the other.
- Sits between producer stages and the shared mux/result bus of the single-cycle processor datapath.

Parameters:
- LARGURA, 4, data width of Entrada0/Entrada1/Resultado.
- MAX_RAJADA, 4, maximum consecutive granted beats per owner while the other requester is waiting (legal range >= 1).

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Requisicao0  input  1  requester 0 wants the mux; level, held while it has data.
- Requisicao1  input  1  requester 1, same semantics.
- Entrada0  input  LARGURA  requester 0 data.
- Entrada1  input  LARGURA  requester 1 data.
- Concessao0  output  1  registered; requester 0 owns the mux this cycle.
- Concessao1  output  1  registered; requester 1 owns the mux this cycle.
- Controle  output  1  registered mux select; 0 selects Entrada0, 1 selects Entrada1.
- Resultado  output  LARGURA  registered selected word.
- Valido  output  1  Resultado holds a new beat this cycle.

Behaviour:
- Reset (sync, at the edge where Reset=1):
  - estado=OCIOSO.
  - Concessao0=Concessao1=0, Controle=0, Resultado=0, Valido=0.
  - contador=0, ultimo=1, so the first tie goes to requester 0.
  - Reset asserted mid-burst drops the in-flight beat; no output appears after reset.
- States: OCIOSO, DONO0, DONO1.
  - Concessao0 is high only in DONO0, Concessao1 only in DONO1.
  - Controle=0 in OCIOSO/DONO0 and 1 in DONO1.
- OCIOSO:
  - Only Requisicao0 -> DONO0. Only Requisicao1 -> DONO1.
  - Both -> the requester != ultimo. Neither -> stay.
  - Grant rises on the edge after the request is seen, giving 1 cycle of arbitration latency.
- DONOn, beat accepted when Requisicao_n=1:
  - Resultado <= Entrada_n and Valido <= 1 at the next edge (1 cycle data latency).
  - contador increments.
- DONOn, Requisicao_n=0 (release):
  - No beat is taken; Valido <= 0 next cycle.
  - Other requester active -> DONO(other). Otherwise -> OCIOSO.
  - ultimo <= n; contador <= 0.
- DONOn, burst limit:
  - When a beat is accepted with contador==MAX_RAJADA-1 and the other requester is active, switch to DONO(other) at the same edge, with no idle bubble.
  - On the switch: ultimo <= n; contador <= 0.
  - If the other requester is inactive at the limit, contador wraps to 0 and ownership is kept.
- Valido=0 in every cycle without an accepted beat. Resultado holds its last value whenever Valido=0.
- Concessao0 and Concessao1 are never both 1. Controle always matches the asserted grant.
- contador width is clog2(MAX_RAJADA), minimum 1 bit; no arithmetic overflow is possible.
- Data words pass unmodified; the block does no arithmetic on data.

Optional Feature:
- Macro: ARBITRO_PRIORIDADE_FIXA_EN.
- Defined:
  - Fixed priority: requester 0 always wins ties in OCIOSO, and ultimo is ignored.
  - The burst limit applies only to DONO1. Requester 0 is never preempted and keeps the mux until it releases.
- Undefined: round-robin plus MAX_RAJADA limit for both requesters, as described above.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles, no requests -> all outputs 0, estado OCIOSO, Controle=0 indefinitely.
- Single requester: Requisicao0=1 with Entrada0=4'b0111 for 3 cycles.
  - Concessao0 rises 1 cycle after the request.
  - Resultado=0111 with Valido=1 for 3 cycles, 1 cycle after each grant cycle.
  - Then Valido=0 and return to OCIOSO.
- Simultaneous first request: both requesters high from reset, Entrada0=4'b0111, Entrada1=4'b0000, MAX_RAJADA=4.
  - Concessao0 for 4 beats (Resultado=0111), then Concessao1 for 4 beats (Resultado=0000), then alternating.
  - Controle toggles 0->1 with no bubble.
- Early release: in DONO0 drop Requisicao0 after 2 beats while Requisicao1=1.
  - Next edge Concessao1=1, Controle=1.
  - Valido=0 for exactly one cycle between bursts.
- Reset mid-burst: assert Reset during the third beat of DONO1 -> next edge all outputs 0, no Valido pulse; after Reset releases with both requesting, requester 0 wins (ultimo=1).
- Feature ARBITRO_PRIORIDADE_FIXA_EN defined, both requesting continuously -> Concessao0 held for 20+ cycles, Concessao1 never asserted until Requisicao0 drops.
